// File: rtl/hirose_pkg.sv
// rtl/hirose_pkg.sv - shared sizes, default chaining values and FSM states for the Hirose/PRESENT hash
package hirose_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int HASH_SIZE  = 128;
  localparam int KEY_SIZE   = 128;

  localparam logic [BLOCK_SIZE-1:0] DEF_IV_G    = 64'h0;
  localparam logic [BLOCK_SIZE-1:0] DEF_IV_H    = 64'h0;
  localparam logic [BLOCK_SIZE-1:0] DEF_CONST_C = 64'h0000_0000_0000_0001;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START_G = 3'd1,
    S_WAIT_G  = 3'd2,
    S_START_H = 3'd3,
    S_WAIT_H  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/hirose_present_uut_present_core.sv
// rtl/hirose_present_uut_present_core.sv - round-based PRESENT-128 encryptor, done 32 cycles after start
module present_core
  import hirose_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEY_SIZE-1:0]   key_i,
  input  logic [BLOCK_SIZE-1:0] pt_i,
  output logic [BLOCK_SIZE-1:0] ct_o,
  output logic                  done_o
);

  logic [BLOCK_SIZE-1:0] state_q, state_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic [4:0]            rnd_q, rnd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [BLOCK_SIZE-1:0] sb;
  logic [BLOCK_SIZE-1:0] perm;
  logic [KEY_SIZE-1:0]   key_rot;
  logic [KEY_SIZE-1:0]   key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // One round: add round key, sbox layer, bit permutation; key schedule runs alongside.
  always_comb begin
    sb   = '0;
    perm = '0;
    for (int i = 0; i < 16; i++) begin
      sb[4*i +: 4] = sbox(state_q[4*i +: 4] ^ key_q[64+4*i +: 4]);
    end
    for (int i = 0; i < 63; i++) begin
      perm[(i*16) % 63] = sb[i];
    end
    perm[63] = sb[63];
    key_rot  = {key_q[66:0], key_q[127:67]};
    key_next = key_rot;
    key_next[127:124] = sbox(key_rot[127:124]);
    key_next[123:120] = sbox(key_rot[123:120]);
    key_next[66:62]   = key_rot[66:62] ^ rnd_q;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start && !busy_q) begin
      state_d = pt_i;
      key_d   = key_i;
      rnd_d   = 5'd1;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      state_d = perm;
      key_d   = key_next;
      rnd_d   = rnd_q + 5'd1;
      if (rnd_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // After round 31 the key register already holds K32, so the final whitening is combinational.
  assign ct_o   = state_q ^ key_q[127:64];
  assign done_o = done_q;

endmodule

// File: rtl/hirose_present_uut.sv
// rtl/hirose_present_uut.sv - single-block Hirose compression over one shared PRESENT-128 core
module hirose_present_uut
  import hirose_pkg::*;
#(
  parameter logic [BLOCK_SIZE-1:0] IV_G    = DEF_IV_G,
  parameter logic [BLOCK_SIZE-1:0] IV_H    = DEF_IV_H,
  parameter logic [BLOCK_SIZE-1:0] CONST_C = DEF_CONST_C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BLOCK_SIZE-1:0] block_i,
  output logic [HASH_SIZE-1:0]  hash_o,
  output logic                  end_o
);

  state_t                state_q, state_d;
  logic [BLOCK_SIZE-1:0] m_q, m_d;
  logic [BLOCK_SIZE-1:0] g_q, g_d;
  logic [BLOCK_SIZE-1:0] h_q, h_d;
  logic                  start_q, start_d;
  logic [BLOCK_SIZE-1:0] ct;
  logic                  ct_done;
  logic [BLOCK_SIZE-1:0] pt;

  // start_q is high exactly while in a START_* state, so pt follows the state.
  assign pt = (state_q == S_START_G) ? IV_G : (IV_G ^ CONST_C);

  present_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start_q),
    .key_i  ({IV_H, m_q}),
    .pt_i   (pt),
    .ct_o   (ct),
    .done_o (ct_done)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    h_d     = h_q;
    start_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        m_d     = block_i;
        start_d = 1'b1;
        state_d = S_START_G;
      end
      S_START_G: state_d = S_WAIT_G;
      S_WAIT_G: begin
        if (ct_done) begin
          g_d     = ct ^ IV_G;
          start_d = 1'b1;
          state_d = S_START_H;
        end
      end
      S_START_H: state_d = S_WAIT_H;
      S_WAIT_H: begin
        if (ct_done) begin
          h_d     = ct ^ IV_G ^ CONST_C;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      m_q     <= '0;
      g_q     <= '0;
      h_q     <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      g_q     <= g_d;
      h_q     <= h_d;
      start_q <= start_d;
    end
  end

  assign end_o  = (state_q == S_DONE);
  assign hash_o = end_o ? {g_q, h_q} : '0;

endmodule

// File: tb/tb_hirose_present_uut.sv
// tb/tb_hirose_present_uut.sv - randomized self-checking bench against a behavioural Hirose/PRESENT model
module tb_hirose_present_uut;

  localparam logic [63:0] G2       = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] H2       = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] C2       = 64'h8000_0000_0000_0003;
  localparam logic [63:0] SBOX_TAB = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] ZERO_CT  = 64'h96db_702a_2e69_00af;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [63:0]   block = 64'h0;
  logic [127:0]  hash_a, hash_b;
  logic          end_a, end_b;
  logic          c_rst = 1'b1, c_start = 1'b0;
  logic [63:0]   c_ct;
  logic          c_done;

  hirose_present_uut dut_a (
    .clk(clk), .rst(rst), .block_i(block), .hash_o(hash_a), .end_o(end_a)
  );

  hirose_present_uut #(.IV_G(G2), .IV_H(H2), .CONST_C(C2)) dut_b (
    .clk(clk), .rst(rst), .block_i(block), .hash_o(hash_b), .end_o(end_b)
  );

  present_core u_core (
    .clk(clk), .rst(c_rst), .start(c_start), .key_i(128'h0), .pt_i(64'h0),
    .ct_o(c_ct), .done_o(c_done)
  );

  int           checks = 0;
  int           failures = 0;
  int           n = -2;
  logic [127:0] exp_a = '0, exp_b = '0;

  function automatic logic [63:0] present_enc(input logic [127:0] key, input logic [63:0] pt);
    logic [63:0]  s, t;
    logic [127:0] k;
    logic [4:0]   rc;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[127:64];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = SBOX_TAB[4*s[4*j +: 4] +: 4];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : ((i * 16) % 63)] = s[i];
      s = t;
      k = {k[66:0], k[127:67]};
      k[127:124] = SBOX_TAB[4*k[127:124] +: 4];
      k[123:120] = SBOX_TAB[4*k[123:120] +: 4];
      rc = 5'(r);
      k[66:62] = k[66:62] ^ rc;
    end
    return s ^ k[127:64];
  endfunction

  function automatic logic [127:0] hirose(input logic [63:0] ivg, input logic [63:0] ivh,
                                          input logic [63:0] c, input logic [63:0] m);
    logic [127:0] key;
    key = {ivh, m};
    return {present_enc(key, ivg) ^ ivg, present_enc(key, ivg ^ c) ^ ivg ^ c};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Advance one clock: model the edge, then compare both hashes on the falling edge.
  task automatic tick();
    logic exp_end;
    @(posedge clk);
    if (rst) begin
      n = -1;
    end else begin
      n = n + 1;
      if (n == 0) begin
        exp_a = hirose(64'h0, 64'h0, 64'h1, block);
        exp_b = hirose(G2, H2, C2, block);
      end
    end
    @(negedge clk);
    if (n >= -1) begin
      exp_end = (n >= 66);
      check("end_a", 128'(end_a), 128'(exp_end));
      check("hash_a", hash_a, exp_end ? exp_a : 128'h0);
      check("end_b", 128'(end_b), 128'(exp_end));
      check("hash_b", hash_b, exp_end ? exp_b : 128'h0);
    end
  endtask

  task automatic wait_end(input int already);
    int cnt;
    cnt = already;
    while (!end_a && cnt < 120) begin
      tick();
      cnt++;
    end
    check("end_rise_cycles", 128'(cnt), 128'd67);
  endtask

  initial begin
    int           lat;
    logic [127:0] snap;

    check("model_zero_vector", 128'(present_enc(128'h0, 64'h0)), 128'(ZERO_CT));

    repeat (3) tick();
    check("rst_end", 128'(end_a), 128'h0);
    check("rst_hash", hash_a, 128'h0);

    c_rst = 1'b0;
    tick();
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    lat = 0;
    while (!c_done && lat < 40) begin
      tick();
      lat++;
    end
    check("core_latency", 128'(lat + 1), 128'd32);
    check("core_ct", 128'(c_ct), 128'(ZERO_CT));

    // M = 0 with default IVs, then a long hold in DONE
    block = 64'h0;
    rst = 1'b0;
    wait_end(0);
    check("m0_g1", 128'(hash_a[127:64]), 128'(ZERO_CT));
    snap = hash_a;
    repeat (200) tick();
    check("hold_end", 128'(end_a), 128'h1);
    check("hold_hash", hash_a, snap);
    rst = 1'b1;
    tick();

    block = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b0;
    wait_end(0);
    rst = 1'b1;
    tick();

    block = 64'h0123_4567_89AB_CDEF;
    rst = 1'b0;
    wait_end(0);
    rst = 1'b1;
    tick();

    // abort during WAIT_H, then hash a different block
    block = {$urandom, $urandom};
    rst = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("abort_end", 128'(end_a), 128'h0);
    check("abort_hash", hash_b, 128'h0);
    block = {$urandom, $urandom};
    rst = 1'b0;
    wait_end(0);
    rst = 1'b1;
    tick();

    // block_i wiggles after LOAD must not matter
    block = {$urandom, $urandom};
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 60; i++) begin
      block = {$urandom, $urandom};
      tick();
    end
    wait_end(61);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      block = {$urandom, $urandom};
      rst = 1'b0;
      wait_end(0);
      repeat ($urandom_range(1, 5)) tick();
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hirose_present_uut.md
# hirose_present_uut

Unit-under-test block for the hash autotest: a single-block Hirose double-block-length compression function built on PRESENT-128. It sits directly downstream of the autotest FSM. It takes the FSM's `rst_uut` as its reset and its 64-bit `plaintext_uut` as the message block. It returns the 128-bit digest and a completion flag, which the FSM samples into its result register and timer logic.

## Interface
Parameters:
- `IV_G`, default `64'h0`: initial chaining value G0.
- `IV_H`, default `64'h0`: initial chaining value H0.
- `CONST_C`, default `64'h0000_0000_0000_0001`: Hirose separation constant c. It must be non-zero.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset, driven by the FSM's `rst_uut`.
- `block_i` input, 64 bits: message block M, taken from `plaintext_uut`.
- `hash_o` output, 128 bits: digest `{G1, H1}`. G1 is on `[127:64]` and H1 is on `[63:0]`.
- `end_o` output, 1 bit: completion flag, connected to `end_uut`.

## Operation
Function:
- Cipher key K = `{IV_H, M}`, with H0 on `K[127:64]`.
- G1 = E_K(G0) xor G0.
- H1 = E_K(G0 xor c) xor G0 xor c.

There is no start input. Hashing begins automatically on the first cycle with `rst` low.

A single cipher instance is used twice in sequence:
- `LOAD`: register `block_i` into `m_q`. Go to `START_G`.
- `START_G`: pulse cipher `start`, with pt = G0 and key = `{IV_H, m_q}`. Go to `WAIT_G`.
- `WAIT_G`: on cipher `done`, set `g_q` <= ct xor G0. Go to `START_H`.
- `START_H`: pulse `start`, with pt = G0 xor c and the same key. Go to `WAIT_H`.
- `WAIT_H`: on `done`, set `h_q` <= ct xor G0 xor c. Go to `DONE`.
- `DONE`: `end_o` = 1. `hash_o` = `{g_q, h_q}`. The block stays in `DONE` until `rst` is asserted.

Reset behaviour:
- Reset values: state = `LOAD`, `m_q` = 0, `g_q` = 0, `h_q` = 0, `hash_o` = 0, `end_o` = 0.
- `hash_o` reads 0 until the block reaches `DONE`. No partial G1 is exposed.
- Reset in any state, including mid-encryption, aborts immediately. The cipher instance is reset too, so a stale `done` can never be consumed after release.
- `block_i` is sampled only in `LOAD`. Later changes to it have no effect until the next reset.
- All XORs are 64 bits wide. There are no carries.

## Timing
- Cycle 0 is the first rising edge with `rst` = 0. That edge performs `LOAD`.
- Cipher latency L = 32 cycles: `done` is a 1-cycle pulse exactly L cycles after `start`, and `ct` is valid in that cycle.
- `START_G` is at cycle 1. `done` arrives at cycle 33 and G1 is captured there.
- `START_H` is at cycle 34. `done` arrives at cycle 66 and H1 is captured there.
- `end_o` and the final `hash_o` are first visible after the edge at cycle 66. The fixed total latency is 2L+3 = 67 cycles from reset release.
- `end_o` is a level, not a pulse. It stays high until `rst` and deasserts the cycle after `rst` is sampled high.
- The cipher's `start` is a registered 1-cycle pulse. It is never asserted while the cipher is busy.

## Structure
- Package `hirose_pkg`:
  - `BLOCK_SIZE` = 64, `HASH_SIZE` = 128, `KEY_SIZE` = 128.
  - Default `IV_G`, `IV_H`, `CONST_C`.
  - `state_t`, an enum of the six states above.
- One sub-module, `present_core`:
  - Round-based PRESENT-128 encryptor.
  - Ports: `clk`, `rst`, `start`, `key_i[127:0]`, `pt_i[63:0]`, `ct_o[63:0]`, `done_o`.
  - 31 rounds plus the final key add, finishing in L = 32 cycles.
  - Contains the sbox/pLayer and the key schedule.
- Top level: the FSM, the `m_q`/`g_q`/`h_q` registers and the output muxing.

## Test plan
- PRESENT core alone: key = 0, pt = 0 -> `ct_o` = `64'h96db702a2e6900af`, with `done_o` 32 cycles after `start`.
- Hash, default parameters, M = 0:
  - `hash_o[127:64]` = `64'h96db702a2e6900af`.
  - `hash_o[63:0]` matches the Python golden model.
  - `end_o` rises at cycle 67.
- M = `64'hFFFF_FFFF_FFFF_FFFF` and M = `64'h0123_4567_89AB_CDEF`, both with non-default IVs -> `hash_o` matches the golden model bit-exactly. `hash_o` reads 0 at every cycle before `end_o` rises.
- Assert `rst` at cycle 40, during `WAIT_H`, with M = A, then release with M = B:
  - `end_o` = 0 and `hash_o` = 0 the cycle after reset.
  - The result equals H(B), and `end_o` rises 67 cycles after the second release.
- Change `block_i` at cycles 1 to 60 -> digest still equals H of the value sampled at cycle 0.
- Hold `rst` low for 200 cycles after completion -> `end_o` stays 1 and `hash_o` is stable, with no second encryption started.
